// File: rtl/linecard_rx_arbiter_if.sv
// Receive/merged-stream bundle for the line card rx arbiter.
// Per-port AXI-stream inputs packed side by side, one tagged output stream.
interface linecard_rx_arbiter_if #(
  parameter int NUM_PORTS     = 24,
  parameter int DATA_WIDTH    = 32,
  parameter int PORT_ID_WIDTH = 5
);
  logic [NUM_PORTS-1:0]              rx_tvalid;
  logic [NUM_PORTS-1:0]              rx_tready;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   rx_tdata;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] rx_tkeep;
  logic [NUM_PORTS-1:0]              rx_tlast;
  logic [NUM_PORTS-1:0]              rx_tuser;
  logic                              tx_tvalid;
  logic                              tx_tready;
  logic [DATA_WIDTH-1:0]             tx_tdata;
  logic [DATA_WIDTH/8-1:0]           tx_tkeep;
  logic                              tx_tlast;
  logic                              tx_tuser;
  logic [PORT_ID_WIDTH-1:0]          tx_tid;

  modport slave (
    input  rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser,
    input  tx_tready,
    output rx_tready,
    output tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser, tx_tid
  );

  modport master (
    output rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser,
    output tx_tready,
    input  rx_tready,
    input  tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser, tx_tid
  );
endinterface

// File: rtl/linecard_rx_arbiter.sv
// Packet-atomic N-port rx arbiter: merges per-port streams into one
// tagged stream, drains disabled ports at frame boundaries.
module linecard_rx_arbiter #(
  parameter int NUM_PORTS     = 24,
  parameter int DATA_WIDTH    = 32,
  parameter int PORT_ID_WIDTH = 5,
  parameter int BASE_PORT     = 0,
  parameter int ARB_MODE      = 0
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [NUM_PORTS-1:0] port_enable,
  linecard_rx_arbiter_if.slave bus,
  output logic [31:0]          fwd_frames,
  output logic [31:0]          drop_frames
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [IW-1:0]        gnt;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win;
  logic                 found;
  int                   j;
  logic [NUM_PORTS-1:0] mode;
  logic [NUM_PORTS-1:0] in_frame;
  logic [NUM_PORTS-1:0] in_frame_nxt;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] sel;
  logic [NUM_PORTS-1:0] rdy;
  logic [NUM_PORTS-1:0] rx_hs;
  logic [NUM_PORTS-1:0] drain_last;
  logic                 granted;
  logic                 tx_hs_last;
  logic [31:0]          drop_inc;
  logic [31:0]          tid_sum;

  assign granted = (state == GRANT);
  assign req     = bus.rx_tvalid & mode;
  assign tid_sum = 32'(BASE_PORT) + 32'(gnt);

  always_comb begin
    bus.tx_tvalid = granted & bus.rx_tvalid[gnt];
    bus.tx_tdata  = bus.rx_tdata[gnt*DATA_WIDTH +: DATA_WIDTH];
    bus.tx_tkeep  = bus.rx_tkeep[gnt*KW +: KW];
    bus.tx_tlast  = granted & bus.rx_tlast[gnt];
    bus.tx_tuser  = granted & bus.rx_tuser[gnt];
    bus.tx_tid    = granted ? tid_sum[PORT_ID_WIDTH-1:0] : '0;
  end

  assign tx_hs_last = bus.tx_tvalid & bus.tx_tready & bus.tx_tlast;

  // The granted port follows tx_tready even if it was disabled while
  // waiting, so a granted frame is never split between tx and drain.
  always_comb begin
    sel          = '0;
    rdy          = '0;
    rx_hs        = '0;
    in_frame_nxt = in_frame;
    drain_last   = '0;
    drop_inc     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel[i]          = granted && (gnt == IW'(i));
      rdy[i]          = sel[i] ? bus.tx_tready : ~mode[i];
      rx_hs[i]        = bus.rx_tvalid[i] & rdy[i];
      if (rx_hs[i])
        in_frame_nxt[i] = ~bus.rx_tlast[i];
      drain_last[i]   = rx_hs[i] & bus.rx_tlast[i]
                      & ~mode[i] & ~sel[i];
      drop_inc        = drop_inc + 32'(drain_last[i]);
    end
  end

  assign bus.rx_tready = rdy;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    if (ARB_MODE == 0) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        j = int'(ptr) + k;
        if (j >= NUM_PORTS)
          j = j - NUM_PORTS;
        if (!found && req[j]) begin
          win   = IW'(j);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--)
        if (req[k])
          win = IW'(k);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      gnt         <= '0;
      ptr         <= '0;
      mode        <= '1;
      in_frame    <= '0;
      fwd_frames  <= '0;
      drop_frames <= '0;
    end else begin
      in_frame    <= in_frame_nxt;
      // Mode only follows enable at a frame boundary.
      mode        <= (mode & in_frame_nxt)
                   | (port_enable & ~in_frame_nxt);
      fwd_frames  <= fwd_frames + 32'(tx_hs_last);
      drop_frames <= drop_frames + drop_inc;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= win;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (tx_hs_last) begin
            state <= IDLE;
            ptr   <= (gnt == IW'(NUM_PORTS - 1)) ? '0
                   : gnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_linecard_rx_arbiter.sv
// Directed bench for linecard_rx_arbiter: round-robin and fixed-priority
// instances share one set of per-port frame sources.
module tb_linecard_rx_arbiter;
  localparam int NP = 24;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int TW = 5;

  typedef struct packed {
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic [NP-1:0] port_enable;
  logic [31:0]   fwd_a, drop_a, fwd_b, drop_b;

  always #5 aclk = ~aclk;

  linecard_rx_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW),
    .PORT_ID_WIDTH(TW)) bus_a ();
  linecard_rx_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW),
    .PORT_ID_WIDTH(TW)) bus_b ();

  assign bus_b.rx_tvalid = bus_a.rx_tvalid;
  assign bus_b.rx_tdata  = bus_a.rx_tdata;
  assign bus_b.rx_tkeep  = bus_a.rx_tkeep;
  assign bus_b.rx_tlast  = bus_a.rx_tlast;
  assign bus_b.rx_tuser  = bus_a.rx_tuser;
  assign bus_b.tx_tready = bus_a.tx_tready;

  linecard_rx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW),
    .PORT_ID_WIDTH(TW), .BASE_PORT(0), .ARB_MODE(0)) dut_rr (
    .aclk(aclk), .areset_n(areset_n), .port_enable(port_enable),
    .bus(bus_a), .fwd_frames(fwd_a), .drop_frames(drop_a));

  linecard_rx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW),
    .PORT_ID_WIDTH(TW), .BASE_PORT(0), .ARB_MODE(1)) dut_fp (
    .aclk(aclk), .areset_n(areset_n), .port_enable(port_enable),
    .bus(bus_b), .fwd_frames(fwd_b), .drop_frames(drop_b));

  int    checks = 0;
  int    failures = 0;
  int    remaining [NP];
  int    flen [NP];
  int    beat [NP];
  int    fno [NP];
  bit    errf [NP];
  bit    use_b;
  beat_t log_q [$];
  int    nfr;
  logic  s_valid, s_ready;
  beat_t s_b;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bit l;
    for (int i = 0; i < NP; i++) begin
      l = (beat[i] == flen[i] - 1);
      bus_a.rx_tvalid[i] = (remaining[i] > 0);
      bus_a.rx_tlast[i]  = l;
      bus_a.rx_tuser[i]  = l & errf[i];
      bus_a.rx_tdata[i*DW +: DW] = {8'(i), 8'(fno[i]), 16'(beat[i])};
      bus_a.rx_tkeep[i*KW +: KW] = l ? 4'h7 : 4'hF;
    end
  endtask

  task automatic step();
    logic [NP-1:0] rdy, hs;
    @(negedge aclk);
    rdy = use_b ? bus_b.rx_tready : bus_a.rx_tready;
    hs  = bus_a.rx_tvalid & rdy;
    if (use_b) begin
      s_valid = bus_b.tx_tvalid;
      s_b = {bus_b.tx_tid, bus_b.tx_tdata, bus_b.tx_tkeep,
             bus_b.tx_tlast, bus_b.tx_tuser};
    end else begin
      s_valid = bus_a.tx_tvalid;
      s_b = {bus_a.tx_tid, bus_a.tx_tdata, bus_a.tx_tkeep,
             bus_a.tx_tlast, bus_a.tx_tuser};
    end
    s_ready = bus_a.tx_tready;
    if (s_valid && s_ready) begin
      log_q.push_back(s_b);
      if (s_b.last) nfr++;
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (hs[i]) begin
        if (beat[i] == flen[i] - 1) begin
          beat[i] = 0;
          fno[i]++;
          remaining[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    use_b = 1'b0;
    for (int i = 0; i < NP; i++) begin
      remaining[i] = 0;
      beat[i] = 0;
      fno[i] = 0;
      flen[i] = 4;
      errf[i] = 1'b0;
    end
    port_enable = '1;
    bus_a.tx_tready = 1'b1;
    drive();
    log_q.delete();
    nfr = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset_n = 1'b1;
  endtask

  task automatic wait_frames(string tag, int n, int budget,
                             output int used);
    used = 0;
    while (nfr < n && used < budget) begin
      step();
      used++;
    end
    chk(tag, 64'(nfr >= n), 64'd1);
  endtask

  initial begin
    int used, errs, c;
    logic pv, pr;
    beat_t pb;

    // Reset values while every port presents a last/err beat
    do_reset();
    areset_n = 1'b0;
    for (int i = 0; i < NP; i++) begin
      remaining[i] = 1;
      flen[i] = 1;
      errf[i] = 1'b1;
    end
    drive();
    #2;
    chk("rst_rx_tready", 64'(bus_a.rx_tready), 64'd0);
    chk("rst_tx_tvalid", 64'(bus_a.tx_tvalid), 64'd0);
    chk("rst_tx_tlast", 64'(bus_a.tx_tlast), 64'd0);
    chk("rst_tx_tuser", 64'(bus_a.tx_tuser), 64'd0);
    chk("rst_tx_tid", 64'(bus_a.tx_tid), 64'd0);
    chk("rst_fwd", 64'(fwd_a), 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);

    // Two simultaneous 17-beat frames, RR from ptr 0
    do_reset();
    remaining[1] = 1; flen[1] = 17;
    remaining[2] = 1; flen[2] = 17;
    drive();
    step();
    chk("lat_idle", 64'(s_valid), 64'd0);
    step();
    chk("lat_first", 64'({s_valid, s_b.tid}), 64'({1'b1, 5'd1}));
    wait_frames("t1_timeout", 2, 100, used);
    chk("t1_beats", 64'(log_q.size()), 64'd34);
    errs = 0;
    for (int k = 0; k < log_q.size() && k < 34; k++) begin
      int p, b;
      p = (k < 17) ? 1 : 2;
      b = (k < 17) ? k : k - 17;
      if (log_q[k] !== {5'(p), 8'(p), 8'd0, 16'(b),
                        (b == 16) ? 4'h7 : 4'hF, b == 16, 1'b0})
        errs++;
    end
    chk("t1_order", 64'(errs), 64'd0);
    chk("t1_fwd", 64'(fwd_a), 64'd2);

    // Ports 0,3,23 with 4-beat frames: RR order and 5 cycles per frame
    do_reset();
    remaining[0] = 2; remaining[3] = 2; remaining[23] = 2;
    drive();
    wait_frames("t2_timeout", 6, 100, used);
    chk("t2_cycles", 64'(used), 64'd30);
    chk("t2_beats", 64'(log_q.size()), 64'd24);
    if (log_q.size() == 24) begin
      chk("t2_tid_order", 64'({log_q[0].tid, log_q[4].tid,
        log_q[8].tid, log_q[12].tid, log_q[16].tid, log_q[20].tid}),
        64'({5'd0, 5'd3, 5'd23, 5'd0, 5'd3, 5'd23}));
    end
    chk("t2_fwd", 64'(fwd_a), 64'd6);

    // Same stimulus under fixed priority: port 0 wins every time
    do_reset();
    use_b = 1'b1;
    remaining[0] = 3; remaining[3] = 5; remaining[23] = 5;
    drive();
    wait_frames("t3_timeout", 3, 100, used);
    chk("t3_cycles", 64'(used), 64'd15);
    errs = 0;
    foreach (log_q[k])
      if (log_q[k].tid !== 5'd0) errs++;
    chk("t3_all_port0", 64'(errs), 64'd0);
    chk("t3_fwd", 64'(fwd_b), 64'd3);

    // Disable port 2 mid-frame: frame completes, next frame drained
    do_reset();
    remaining[2] = 1; flen[2] = 10;
    drive();
    c = 0;
    while (beat[2] != 5 && c < 40) begin
      step();
      c++;
    end
    chk("t4_reach_beat5", 64'(beat[2]), 64'd5);
    port_enable[2] = 1'b0;
    wait_frames("t4_timeout", 1, 40, used);
    chk("t4_first_beats", 64'(log_q.size()), 64'd10);
    flen[2] = 8; remaining[2] = 1;
    remaining[5] = 1; flen[5] = 4;
    drive();
    c = 0;
    while (remaining[2] > 0 && c < 40) begin
      step();
      c++;
    end
    chk("t4_drain_cycles", 64'(c), 64'd8);
    wait_frames("t4_timeout2", 2, 40, used);
    chk("t4_drop", 64'(drop_a), 64'd1);
    chk("t4_fwd", 64'(fwd_a), 64'd2);
    chk("t4_total_beats", 64'(log_q.size()), 64'd14);
    errs = 0;
    foreach (log_q[k])
      if ((k < 10 && log_q[k].tid !== 5'd2) ||
          (k >= 10 && log_q[k].tid !== 5'd5)) errs++;
    chk("t4_tids", 64'(errs), 64'd0);

    // tx_tready toggling during a 10-beat frame with error on last beat
    do_reset();
    remaining[7] = 1; flen[7] = 10; errf[7] = 1'b1;
    drive();
    c = 0; errs = 0; pv = 1'b0; pr = 1'b1; pb = '0;
    while (nfr < 1 && c < 60) begin
      step();
      if (c > 0 && pv && !pr && {s_valid, s_b} !== {pv, pb})
        errs++;
      pv = s_valid; pr = s_ready; pb = s_b;
      bus_a.tx_tready = ~bus_a.tx_tready;
      c++;
    end
    chk("t5_done", 64'(nfr), 64'd1);
    chk("t5_stable", 64'(errs), 64'd0);
    chk("t5_beats", 64'(log_q.size()), 64'd10);
    errs = 0;
    foreach (log_q[k])
      if (log_q[k].tid !== 5'd7 || log_q[k].user !== (k == 9)) errs++;
    chk("t5_tid_user", 64'(errs), 64'd0);
    if (log_q.size() == 10)
      chk("t5_last_user", 64'({log_q[9].last, log_q[9].user}), 64'd3);
    chk("t5_fwd", 64'(fwd_a), 64'd1);
    bus_a.tx_tready = 1'b1;

    // Reset mid-frame: async clear, pointer restarts at 0
    do_reset();
    remaining[9] = 1;
    drive();
    wait_frames("t6_timeout", 1, 40, used);
    chk("t6_pre_fwd", 64'(fwd_a), 64'd1);
    remaining[4] = 1; flen[4] = 6;
    drive();
    c = 0;
    while (beat[4] != 3 && c < 40) begin
      step();
      c++;
    end
    chk("t6_reach_beat3", 64'(beat[4]), 64'd3);
    areset_n = 1'b0;
    #1;
    chk("t6_rx_tready", 64'(bus_a.rx_tready), 64'd0);
    chk("t6_tx_tvalid", 64'(bus_a.tx_tvalid), 64'd0);
    chk("t6_tx_tlast", 64'(bus_a.tx_tlast), 64'd0);
    chk("t6_tx_tid", 64'(bus_a.tx_tid), 64'd0);
    chk("t6_fwd", 64'(fwd_a), 64'd0);
    beat[4] = 0; remaining[4] = 1;
    remaining[12] = 1; flen[12] = 4;
    log_q.delete();
    nfr = 0;
    drive();
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    wait_frames("t6_timeout2", 2, 60, used);
    chk("t6_beats", 64'(log_q.size()), 64'd10);
    if (log_q.size() == 10) begin
      chk("t6_first", 64'({log_q[0].tid, log_q[0].data}),
          64'({5'd4, 8'd4, 8'd0, 16'd0}));
      chk("t6_second_tid", 64'(log_q[6].tid), 64'd12);
    end
    chk("t6_post_fwd", 64'(fwd_a), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
